// File: rtl/spart_pkg.sv
// Shared definitions for the spart and its bus-master driver.
package spart_pkg;

  // spart register map seen on ioaddr
  typedef enum logic [1:0] {
    IOA_BUF  = 2'b00,
    IOA_STAT = 2'b01,
    IOA_DBL  = 2'b10,
    IOA_DBH  = 2'b11
  } ioaddr_e;

  // driver FSM states
  typedef enum logic [2:0] {
    ST_CFG_LO,
    ST_CFG_HI,
    ST_IDLE,
    ST_READ,
    ST_WAIT_TBR,
    ST_WRITE
  } drv_state_e;

  localparam int unsigned CLK_FREQ_DEF = 50_000_000;

  // Divisors for the nominal 50 MHz clock, floor(clk / (16 * baud))
  localparam logic [15:0] DIV_4800_DEF  = 16'h028B;
  localparam logic [15:0] DIV_9600_DEF  = 16'h0145;
  localparam logic [15:0] DIV_19200_DEF = 16'h00A2;
  localparam logic [15:0] DIV_38400_DEF = 16'h0051;

  // Divisor for an arbitrary clock, used when CLK_FREQ is overridden
  function automatic logic [15:0] div_calc(input int unsigned clk_hz,
                                           input int unsigned baud);
    int unsigned q;
    q = clk_hz / (16 * baud);
    return q[15:0];
  endfunction

endpackage

// File: rtl/spart_driver.sv
// Bus master for the spart: programs the baud divisor, then echoes every
// received byte and exposes the last byte and an echo count for display.
//
// state       | meaning
// ------------+----------------------------------------------
// CFG_LO      | write divisor low byte (ioaddr 10)
// CFG_HI      | write divisor high byte (ioaddr 11)
// IDLE        | bus released; watch br_cfg changes, then rda
// READ        | read RX buffer (ioaddr 00), capture at cycle end
// WAIT_TBR    | bus released until transmitter is ready
// WRITE       | write captured byte to TX buffer, bump count
module spart_driver
  import spart_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = CLK_FREQ_DEF,
  parameter logic [15:0] DIV_4800  = (CLK_FREQ == CLK_FREQ_DEF) ? DIV_4800_DEF  : div_calc(CLK_FREQ, 4800),
  parameter logic [15:0] DIV_9600  = (CLK_FREQ == CLK_FREQ_DEF) ? DIV_9600_DEF  : div_calc(CLK_FREQ, 9600),
  parameter logic [15:0] DIV_19200 = (CLK_FREQ == CLK_FREQ_DEF) ? DIV_19200_DEF : div_calc(CLK_FREQ, 19200),
  parameter logic [15:0] DIV_38400 = (CLK_FREQ == CLK_FREQ_DEF) ? DIV_38400_DEF : div_calc(CLK_FREQ, 38400)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] br_cfg,
  output logic       iocs,
  output logic       iorw,
  output logic [1:0] ioaddr,
  inout  wire  [7:0] databus,
  input  logic       rda,
  input  logic       tbr,
  output logic [7:0] rx_byte,
  output logic [7:0] rx_count
);

  drv_state_e  state, state_nxt;
  logic        run_q;
  logic [1:0]  br_cfg_q;
  logic [7:0]  data_q;
  logic [15:0] div;
  logic [7:0]  dout;
  ioaddr_e     ioa;

  // run_q is low for the reset cycle so the bus stays idle while state
  // already sits in CFG_LO; the first cycle after release is the CFG_LO access
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_CFG_LO;
      run_q <= 1'b0;
    end else begin
      state <= state_nxt;
      run_q <= 1'b1;
    end
  end

  // Baud select latch, read capture and echo counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      br_cfg_q <= br_cfg;
      data_q   <= 8'h00;
      rx_byte  <= 8'h00;
      rx_count <= 8'h00;
    end else if (run_q) begin
      if (state == ST_IDLE && br_cfg != br_cfg_q)
        br_cfg_q <= br_cfg;
      if (state == ST_READ) begin
        data_q  <= databus;
        rx_byte <= databus;
      end
      if (state == ST_WRITE)
        rx_count <= rx_count + 8'd1;
    end
  end

  // Divisor table indexed by the registered baud select
  always_comb begin
    div = DIV_4800;
    case (br_cfg_q)
      2'b00:   div = DIV_4800;
      2'b01:   div = DIV_9600;
      2'b10:   div = DIV_19200;
      default: div = DIV_38400;
    endcase
  end

  // Next state; a pending reconfiguration wins over a pending byte
  always_comb begin
    state_nxt = state;
    if (!run_q) begin
      state_nxt = ST_CFG_LO;
    end else begin
      case (state)
        ST_CFG_LO:   state_nxt = ST_CFG_HI;
        ST_CFG_HI:   state_nxt = ST_IDLE;
        ST_IDLE: begin
          if (br_cfg != br_cfg_q) state_nxt = ST_CFG_LO;
          else if (rda)           state_nxt = ST_READ;
        end
        ST_READ:     state_nxt = ST_WAIT_TBR;
        ST_WAIT_TBR: if (tbr) state_nxt = ST_WRITE;
        ST_WRITE:    state_nxt = ST_IDLE;
        default:     state_nxt = ST_CFG_LO;
      endcase
    end
  end

  // Bus outputs decoded from registered state only
  always_comb begin
    iocs = 1'b0;
    iorw = 1'b1;
    ioa  = IOA_BUF;
    dout = 8'h00;
    if (run_q) begin
      case (state)
        ST_CFG_LO: begin iocs = 1'b1; iorw = 1'b0; ioa = IOA_DBL; dout = div[7:0];  end
        ST_CFG_HI: begin iocs = 1'b1; iorw = 1'b0; ioa = IOA_DBH; dout = div[15:8]; end
        ST_READ:   begin iocs = 1'b1; iorw = 1'b1; ioa = IOA_BUF; end
        ST_WRITE:  begin iocs = 1'b1; iorw = 1'b0; ioa = IOA_BUF; dout = data_q;    end
        default:   ;
      endcase
    end
  end

  assign ioaddr  = ioa;
  assign databus = (iocs & ~iorw) ? dout : 8'bzzzz_zzzz;

endmodule

// File: tb/tb_spart_driver.sv
// Directed bench for spart_driver with a minimal behavioural spart port.
module tb_spart_driver;

  logic       clk;
  logic       rst_n;
  logic [1:0] br_cfg;
  logic       iocs, iorw;
  logic [1:0] ioaddr;
  wire  [7:0] databus;
  logic       rda, tbr;
  logic [7:0] rx_byte, rx_count;
  logic [7:0] rx_val;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] exp_cnt;

  typedef struct {
    logic [1:0] cfg;
    logic [7:0] lo;
    logic [7:0] hi;
  } cfg_vec_t;
  cfg_vec_t cfg_tbl [4];

  spart_driver dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .br_cfg   (br_cfg),
    .iocs     (iocs),
    .iorw     (iorw),
    .ioaddr   (ioaddr),
    .databus  (databus),
    .rda      (rda),
    .tbr      (tbr),
    .rx_byte  (rx_byte),
    .rx_count (rx_count)
  );

  // spart side: return rx_val on a buffer read
  assign databus = (iocs && iorw && ioaddr == 2'b00) ? rx_val : 8'bzzzz_zzzz;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic check_idle(input string nm);
    chk({nm, "_iocs"}, {15'd0, iocs}, 16'd0);
    chk({nm, "_bus"}, {8'h00, databus}, {8'h00, 8'bzzzz_zzzz});
  endtask

  // Expects CFG_LO at the next negedge, CFG_HI after it, then IDLE
  task automatic check_cfg(input logic [7:0] lo, input logic [7:0] hi);
    @(negedge clk);
    chk("cfg_lo_iocs", {15'd0, iocs}, 16'd1);
    chk("cfg_lo_iorw", {15'd0, iorw}, 16'd0);
    chk("cfg_lo_addr", {14'd0, ioaddr}, 16'd2);
    chk("cfg_lo_data", {8'h00, databus}, {8'h00, lo});
    @(negedge clk);
    chk("cfg_hi_iocs", {15'd0, iocs}, 16'd1);
    chk("cfg_hi_addr", {14'd0, ioaddr}, 16'd3);
    chk("cfg_hi_data", {8'h00, databus}, {8'h00, hi});
    @(negedge clk);
    check_idle("cfg_done");
  endtask

  // Called in IDLE: byte b arrives, READ next cycle, tbr held low for
  // `delay` extra cycles, optional br_cfg change while waiting
  task automatic echo(input logic [7:0] b, input int delay, input int chg_cfg);
    int hold_bad;
    rx_val = b;
    rda    = 1'b1;
    @(negedge clk);
    chk("read_iocs", {15'd0, iocs}, 16'd1);
    chk("read_iorw", {15'd0, iorw}, 16'd1);
    chk("read_addr", {14'd0, ioaddr}, 16'd0);
    rda = 1'b0;
    tbr = (delay == 0);
    @(negedge clk);
    chk("wait_iocs", {15'd0, iocs}, 16'd0);
    chk("rx_byte", {8'h00, rx_byte}, {8'h00, b});
    if (chg_cfg >= 0) br_cfg = chg_cfg[1:0];
    if (delay > 0) begin
      hold_bad = 0;
      repeat (delay) begin
        @(negedge clk);
        if (iocs !== 1'b0) hold_bad++;
      end
      chk("wait_hold", hold_bad[15:0], 16'd0);
      tbr = 1'b1;
    end
    @(negedge clk);
    chk("write_iocs", {15'd0, iocs}, 16'd1);
    chk("write_iorw", {15'd0, iorw}, 16'd0);
    chk("write_addr", {14'd0, ioaddr}, 16'd0);
    chk("write_data", {8'h00, databus}, {8'h00, b});
    exp_cnt = exp_cnt + 8'd1;
    @(negedge clk);
    check_idle("echo_done");
    chk("rx_count", {8'h00, rx_count}, {8'h00, exp_cnt});
  endtask

  initial begin
    cfg_tbl[0] = '{cfg: 2'b01, lo: 8'h45, hi: 8'h01};
    cfg_tbl[1] = '{cfg: 2'b10, lo: 8'hA2, hi: 8'h00};
    cfg_tbl[2] = '{cfg: 2'b11, lo: 8'h51, hi: 8'h00};
    cfg_tbl[3] = '{cfg: 2'b00, lo: 8'h8B, hi: 8'h02};

    rst_n = 1'b0; br_cfg = 2'b00; rda = 1'b0; tbr = 1'b1; rx_val = 8'h00;
    exp_cnt = 8'h00;
    repeat (3) @(negedge clk);
    check_idle("rst");
    chk("rst_iorw", {15'd0, iorw}, 16'd1);
    chk("rst_addr", {14'd0, ioaddr}, 16'd0);
    chk("rst_rx_byte", {8'h00, rx_byte}, 16'd0);
    chk("rst_rx_count", {8'h00, rx_count}, 16'd0);
    rst_n = 1'b1;
    check_cfg(8'h8B, 8'h02);

    for (int i = 0; i < 4; i++) begin
      br_cfg = cfg_tbl[i].cfg;
      check_cfg(cfg_tbl[i].lo, cfg_tbl[i].hi);
    end

    echo(8'hB4, 0, -1);
    echo(8'h5A, 100, -1);

    // reconfigure requested mid-echo: echo finishes, then divisor rewrite
    echo(8'hC3, 3, 3);
    check_cfg(8'h51, 8'h00);

    // rda and br_cfg change together: configure first, byte next
    br_cfg = 2'b01;
    rx_val = 8'hE7;
    rda    = 1'b1;
    check_cfg(8'h45, 8'h01);
    echo(8'hE7, 0, -1);

    // reset during WRITE
    rx_val = 8'h99; rda = 1'b1;
    @(negedge clk);
    chk("rw_read_iocs", {15'd0, iocs}, 16'd1);
    rda = 1'b0; tbr = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rw_write_data", {8'h00, databus}, 16'h0099);
    rst_n = 1'b0;
    @(negedge clk);
    check_idle("rw_abort");
    chk("rw_rx_count", {8'h00, rx_count}, 16'd0);
    chk("rw_rx_byte", {8'h00, rx_byte}, 16'd0);
    rst_n = 1'b1;
    exp_cnt = 8'h00;
    check_cfg(8'h45, 8'h01);

    for (int i = 0; i < 256; i++) echo(8'(i), 0, -1);
    chk("wrap_count", {8'h00, rx_count}, 16'd0);
    chk("last_byte", {8'h00, rx_byte}, 16'h00FF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
